// File: rtl/demux1t4_32_buf_pkg.sv
// demux1t4_32_buf_pkg: shared widths and channel select codes for the buffered 1-to-4 demux
package demux1t4_32_buf_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 8;
   localparam logic [1:0] CH0 = 2'd0;
   localparam logic [1:0] CH1 = 2'd1;
   localparam logic [1:0] CH2 = 2'd2;
   localparam logic [1:0] CH3 = 2'd3;
endpackage

// File: rtl/demux1t4_32_buf_slot.sv
// demux1t4_32_buf_slot: one-entry holding register with valid flag and wrapping accept counter
module demux1t4_32_buf_slot
   import demux1t4_32_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             ready,
   input  logic [WIDTH-1:0] din,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt
);
   // a load on the same edge as a drain wins, so the slot stays full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         cnt   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
         cnt   <= cnt + 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/demux1t4_32_buf.sv
// demux1t4_32_buf: routes one input word to one of four buffered valid/ready channels
module demux1t4_32_buf
   import demux1t4_32_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         s,
   input  logic               i_valid,
   input  logic [WIDTH-1:0]   i_data,
   output logic               i_ready,
   output logic [3:0]         o_valid,
   input  logic [3:0]         o_ready,
   output logic [WIDTH-1:0]   o_data0,
   output logic [WIDTH-1:0]   o_data1,
   output logic [WIDTH-1:0]   o_data2,
   output logic [WIDTH-1:0]   o_data3,
   output logic [4*CNT_W-1:0] cnt
);
   logic [3:0]       load;
   logic [WIDTH-1:0] data_q [4];
   // i_ready deliberately ignores i_valid so the producer can probe before committing
   assign i_ready = !o_valid[s] || o_ready[s];
   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_slot
         assign load[k] = i_valid && i_ready && (s == 2'(k));
         demux1t4_32_buf_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .ready (o_ready[k]),
            .din   (i_data),
            .valid (o_valid[k]),
            .data  (data_q[k]),
            .cnt   (cnt[k*CNT_W +: CNT_W])
         );
      end
   endgenerate
   assign o_data0 = data_q[CH0];
   assign o_data1 = data_q[CH1];
   assign o_data2 = data_q[CH2];
   assign o_data3 = data_q[CH3];
endmodule

// File: tb/tb_demux1t4_32_buf.sv
// tb_demux1t4_32_buf: directed checks of routing, handshake, counters and async reset
module tb_demux1t4_32_buf;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [1:0]  s = 2'd0;
   logic        i_valid = 1'b0;
   logic [31:0] i_data = '0;
   logic        i_ready;
   logic [3:0]  o_valid;
   logic [3:0]  o_ready = 4'b0000;
   logic [31:0] o_data0, o_data1, o_data2, o_data3;
   logic [31:0] cnt;
   int errors = 0;
   int checks = 0;

   demux1t4_32_buf dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s       (s),
      .i_valid (i_valid),
      .i_data  (i_data),
      .i_ready (i_ready),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data0 (o_data0),
      .o_data1 (o_data1),
      .o_data2 (o_data2),
      .o_data3 (o_data3),
      .cnt     (cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", {28'd0, o_valid}, 32'h0);
      chk("rst_cnt", cnt, 32'h0);
      chk("rst_d0", o_data0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      // simple route to ch1, then a blocked second word
      s = 2'd1; i_data = 32'h12345678; i_valid = 1'b1;
      #1 chk("route_rdy", {31'd0, i_ready}, 32'h1);
      step();
      chk("route_valid", {28'd0, o_valid}, 32'h2);
      chk("route_d1", o_data1, 32'h12345678);
      chk("route_cnt1", {24'd0, cnt[15:8]}, 32'h1);
      i_data = 32'h87654321;
      #1 chk("block_rdy", {31'd0, i_ready}, 32'h0);
      step();
      chk("block_d1", o_data1, 32'h12345678);
      chk("block_cnt1", {24'd0, cnt[15:8]}, 32'h1);
      i_valid = 1'b0; o_ready = 4'b0010;
      step();
      chk("drain_valid", {28'd0, o_valid}, 32'h0);
      chk("drain_stale", o_data1, 32'h12345678);
      // back-to-back into ch3 with its consumer always ready
      o_ready = 4'b1000; s = 2'd3;
      for (int i = 0; i < 4; i++) begin
         i_data = 32'hA0 + 32'(i); i_valid = 1'b1;
         #1 chk("b2b_rdy", {31'd0, i_ready}, 32'h1);
         step();
         chk("b2b_valid3", {31'd0, o_valid[3]}, 32'h1);
         chk("b2b_d3", o_data3, 32'hA0 + 32'(i));
      end
      chk("b2b_cnt3", {24'd0, cnt[31:24]}, 32'h4);
      i_valid = 1'b0;
      step();
      chk("b2b_drained", {28'd0, o_valid}, 32'h0);
      o_ready = 4'b0000;
      // ch0 stalled full while ch2 still accepts
      s = 2'd0; i_data = 32'h11; i_valid = 1'b1;
      step();
      chk("ind_v0", {28'd0, o_valid}, 32'h1);
      s = 2'd2; i_data = 32'h55;
      #1 chk("ind_rdy", {31'd0, i_ready}, 32'h1);
      step();
      chk("ind_valid", {28'd0, o_valid}, 32'h5);
      chk("ind_d0", o_data0, 32'h11);
      chk("ind_d2", o_data2, 32'h55);
      chk("ind_cnt2", {24'd0, cnt[23:16]}, 32'h1);
      // redirect from blocked ch0 to free ch1
      s = 2'd0; i_data = 32'h77;
      #1 chk("redir_blk", {31'd0, i_ready}, 32'h0);
      step();
      chk("redir_cnt0a", {24'd0, cnt[7:0]}, 32'h1);
      s = 2'd1;
      #1 chk("redir_rdy", {31'd0, i_ready}, 32'h1);
      step();
      chk("redir_d1", o_data1, 32'h77);
      chk("redir_cnt", cnt, 32'h04_01_02_01);
      chk("redir_valid", {28'd0, o_valid}, 32'h7);
      chk("redir_d0", o_data0, 32'h11);
      // counter wrap on ch0: 254 more words reach 255, one more wraps to 0
      o_ready = 4'b0001; s = 2'd0;
      for (int i = 0; i < 254; i++) begin
         i_data = 32'h1000 + 32'(i);
         step();
      end
      chk("wrap_255", {24'd0, cnt[7:0]}, 32'hFF);
      i_data = 32'hCAFE;
      step();
      chk("wrap_0", cnt, 32'h04_01_02_00);
      chk("wrap_d0", o_data0, 32'hCAFE);
      chk("wrap_valid", {28'd0, o_valid}, 32'h7);
      // replace ch2 content with a same-edge drain+load, then reset mid-cycle
      o_ready = 4'b0100; s = 2'd2; i_data = 32'hDEADBEEF;
      step();
      chk("pre_rst_d2", o_data2, 32'hDEADBEEF);
      chk("pre_rst_cnt2", {24'd0, cnt[23:16]}, 32'h2);
      i_valid = 1'b0; o_ready = 4'b0000;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {28'd0, o_valid}, 32'h0);
      chk("arst_d2", o_data2, 32'h0);
      chk("arst_cnt", cnt, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      s = 2'd2; i_data = 32'h1; i_valid = 1'b1;
      step();
      chk("post_rst_cnt", cnt, 32'h00_01_00_00);
      chk("post_rst_d2", o_data2, 32'h1);
      i_valid = 1'b0;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/demux1t4_32_buf.md
# demux1t4_32_buf

Buffered 1-to-4 demultiplexer: the distribution side of the 4-to-1 32-bit selector used on the datapath. Routes one 32-bit input word to one of four output channels, selected by a 2-bit code. Each channel has a one-entry holding register, a valid/ready handshake and a wrapping transfer counter. It sits wherever a single producer (e.g. a writeback or I/O bus) fans out to four independent consumers.

## Interface
- WIDTH, 32: data width of the input and of each output channel.
- CNT_W, 8: width of each per-channel transfer counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s  in  2  destination select: 0→ch0, 1→ch1, 2→ch2, 3→ch3.
- i_valid  in  1  producer has a word on i_data.
- i_data  in  WIDTH  input word.
- i_ready  out  1  addressed slot can take a word this cycle (combinational).
- o_valid  out  4  bit k: channel k holds an undelivered word.
- o_ready  in  4  bit k: consumer k takes the word this cycle.
- o_data0..o_data3  out  WIDTH each  channel holding registers.
- cnt  out  4*CNT_W  packed per-channel accepted-word counters, ch k at [k*CNT_W +: CNT_W].

## Operation
- Reset (async assert, sync-to-clk deassert is the integrator's job): o_valid=0, o_data0..3=0, cnt=0. Any buffered word is dropped.
- i_ready = !o_valid[s] | o_ready[s]. This depends only on s, slot state and o_ready, and never on i_valid.
- Accept: i_valid & i_ready. On the next edge: o_dataS ← i_data, o_valid[s] ← 1, cnt[s] ← cnt[s]+1 mod 2^CNT_W (255→0 wraps silently).
- Drain of channel k: o_valid[k] & o_ready[k]. If channel k is not loaded on the same edge, o_valid[k] ← 0 and o_data k keeps its stale value.
- Same-slot load and drain on one edge: the new word replaces the old, o_valid stays 1 and the counter increments. Full throughput of one word per cycle per channel.
- The other three channels drain independently of the input in the same cycle.
- o_ready[k] while o_valid[k]=0 is ignored.
- s may change while i_valid is high and nothing is accepted. The producer may redirect, and no stability rule applies before acceptance.
- i_valid low: no state changes except drains.
- o_data k never changes while o_valid[k]=1 unless that channel is reloaded on the same edge as its drain.

## Timing
- Input-to-output latency is 1 cycle: a word accepted at edge n shows o_valid[s]=1 and o_data after edge n.
- i_ready has a combinational path from s and o_ready.
- Outputs o_valid, o_data and cnt are registered and have no combinational path from inputs.
- Reset mid-transfer: rst_n low clears all outputs immediately, without waiting for clk. The first accept after release is counted as 1.

## Structure
- Shared header/package: WIDTH default, CNT_W default, and channel select constants CH0..CH3 = 2'd0..2'd3.
- Sub-module demux_slot: one holding register, valid flag and counter, with load/drain inputs. It is instantiated four times.
- The top level decodes s into a one-hot load vector (load[k] = i_valid & i_ready & (s==k)) and muxes i_ready.

## Test plan
- Reset: assert rst_n=0 mid-cycle with ch2 holding 0xDEADBEEF → o_valid=0000, o_data2=0 and cnt=0 immediately.
- Simple route: s=1, i_data=0x12345678, i_valid=1, o_ready=0 → next cycle o_valid=0010, o_data1=0x12345678, cnt ch1=1. A second word to s=1 sees i_ready=0 and is not accepted.
- Back-to-back same slot: o_ready[3]=1 held, 4 words 0xA0..0xA3 to s=3 on consecutive cycles → i_ready stays 1, o_valid[3]=1 throughout, o_data3 steps through A0..A3, cnt ch3=4.
- Independence: ch0 full and stalled (o_ready[0]=0), send 0x55 to s=2 → accepted in one cycle, ch0 value and valid unchanged.
- Redirect: s=0 blocked with i_valid=1, then switch s to 1 → accepted into ch1, cnt ch0 unchanged.
- Counter wrap: 256 accepted words into ch0 → cnt ch0 returns to 0, no other side effect.
